pheap_level_reader: RTL and testbench

- Read-side client of a single pheap level RAM: the counterpart to the dual-port, 1-cycle-latency, no-change level memory.
- On `start`, sweeps every slot of one level, using port A for even addresses and port B for odd addresses in the same cycle.
- Streams the entries out in index order over a valid/ready interface, buffered through a 4-entry FIFO.
- Reports the minimum key and its slot index at the end of the sweep; used for level dump, debug and heap-order checking.

---
 rtl/pheap_level_reader.sv | 234 +++++++++++++++++++++++
 tb/tb_pheap_level_reader.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pheap_level_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pheap_level_reader
//  Description : Read-side sweeper for one pheap level RAM. Reads two slots
//                per cycle (even on port A, odd on port B), streams entries in
//                index order through a 4-deep FIFO with valid/ready, and
//                reports the minimum key and its slot index at sweep end.
//  Revision    : 1.0 - initial release
// ============================================================================
module pheap_level_reader #(
  parameter int RAMLEVEL = 2,
  parameter int ENTRY_W  = 32,
  parameter int KEY_LSB  = 16,
  parameter int KEY_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  we_a,
  output logic                  we_b,
  output logic [RAMLEVEL-2:0]   addr_a,
  output logic [RAMLEVEL-2:0]   addr_b,
  input  logic [ENTRY_W-1:0]    q_a,
  input  logic [ENTRY_W-1:0]    q_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [RAMLEVEL-2:0]   out_idx,
  output logic [ENTRY_W-1:0]    out_entry,
  output logic                  out_last,
  output logic                  min_valid,
  output logic [KEY_W-1:0]      min_key,
  output logic [RAMLEVEL-2:0]   min_idx
);

  localparam int AW = RAMLEVEL - 1;
  localparam int N  = 1 << AW;
  localparam int NP = N / 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]          r_state;
  logic [1:0]          w_next_state;

  logic [AW-1:0]       r_k;            // pair counter
  logic                r_pending;      // a pair was addressed last cycle
  logic [AW-1:0]       r_addr_a;       // last issued addresses (held when idle)
  logic [AW-1:0]       r_addr_b;
  logic                r_done;
  logic                r_min_valid;
  logic [AW-1:0]       r_head_idx;     // slot index of the FIFO head

  logic [ENTRY_W-1:0]  r_fifo [4];
  logic [1:0]          r_wr_ptr;
  logic [1:0]          r_rd_ptr;
  logic [2:0]          r_cnt;

  logic [KEY_W-1:0]    r_min_key;
  logic [AW-1:0]       r_min_idx;
  logic                r_min_seen;     // tracker holds at least one entry

  logic                w_start_accept;
  logic                w_can_issue;
  logic                w_issue;
  logic                w_finish;
  logic                w_last_pair;
  logic                w_pop;
  logic [AW-1:0]       w_addr_a_new;
  logic [AW-1:0]       w_addr_b_new;

  logic [KEY_W-1:0]    w_key_a;
  logic [KEY_W-1:0]    w_key_b;
  logic                w_b_wins;
  logic [KEY_W-1:0]    w_pair_key;
  logic [AW-1:0]       w_pair_idx;

  assign w_addr_a_new = r_k << 1;
  assign w_addr_b_new = (r_k << 1) | AW'(1);
  assign w_last_pair  = (r_k == AW'(NP - 1));

  // The FIFO plus in-flight reads must never exceed four entries.
  assign w_can_issue  = (({1'b0, r_cnt}) + {2'b00, r_pending, 1'b0}) <= 4'd2;

  assign out_valid    = (r_cnt != 3'd0);
  assign w_pop        = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_READ;
        end
      end
      S_READ: begin
        if (w_can_issue && w_last_pair) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_pending && (r_cnt == 3'd0)) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM-derived control strobes
  always_comb begin
    w_start_accept = 1'b0;
    w_issue        = 1'b0;
    w_finish       = 1'b0;
    case (r_state)
      S_IDLE:  w_start_accept = start;
      S_READ:  w_issue        = w_can_issue;
      S_DRAIN: w_finish       = !r_pending && (r_cnt == 3'd0);
      default: ;
    endcase
  end

  // Addresses are presented in the issue cycle itself so data returns next cycle
  assign addr_a = w_issue ? w_addr_a_new : r_addr_a;
  assign addr_b = w_issue ? w_addr_b_new : r_addr_b;
  assign we_a   = 1'b0;
  assign we_b   = 1'b0;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

  // Sweep control: pair counter, pending flag, held addresses, done/min_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k         <= '0;
      r_pending   <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_done      <= 1'b0;
      r_min_valid <= 1'b0;
      r_head_idx  <= '0;
    end else begin
      r_done    <= w_finish;
      r_pending <= w_issue;
      if (w_start_accept) begin
        r_k         <= '0;
        r_min_valid <= 1'b0;
        r_head_idx  <= '0;
      end else begin
        if (w_issue) begin
          r_k      <= r_k + AW'(1);
          r_addr_a <= w_addr_a_new;
          r_addr_b <= w_addr_b_new;
        end
        if (w_finish) begin
          r_min_valid <= 1'b1;
        end
        if (w_pop) begin
          r_head_idx <= r_head_idx + AW'(1);
        end
      end
    end
  end

  // FIFO storage: both captured words land together, A before B
  always_ff @(posedge clk) begin
    if (r_pending) begin
      r_fifo[r_wr_ptr]          <= q_a;
      r_fifo[r_wr_ptr + 2'd1]   <= q_b;
    end
  end

  // FIFO pointers and occupancy; push and pop may coincide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (r_pending) begin
        r_wr_ptr <= r_wr_ptr + 2'd2;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      r_cnt <= r_cnt + (r_pending ? 3'd2 : 3'd0) - (w_pop ? 3'd1 : 3'd0);
    end
  end

  assign out_entry = out_valid ? r_fifo[r_rd_ptr] : '0;
  assign out_idx   = r_head_idx;
  assign out_last  = out_valid && (r_head_idx == AW'(N - 1));

  // The captured pair's slots are still in the held address registers
  assign w_key_a    = q_a[KEY_LSB +: KEY_W];
  assign w_key_b    = q_b[KEY_LSB +: KEY_W];
  assign w_b_wins   = (w_key_b < w_key_a);
  assign w_pair_key = w_b_wins ? w_key_b  : w_key_a;
  assign w_pair_idx = w_b_wins ? r_addr_b : r_addr_a;

  // Running minimum over captured entries, lowest index wins ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_key  <= '0;
      r_min_idx  <= '0;
      r_min_seen <= 1'b0;
    end else if (w_start_accept) begin
      r_min_seen <= 1'b0;
    end else if (r_pending) begin
      r_min_seen <= 1'b1;
      if (!r_min_seen || (w_pair_key < r_min_key)) begin
        r_min_key <= w_pair_key;
        r_min_idx <= w_pair_idx;
      end
    end
  end

  assign min_valid = r_min_valid;
  assign min_key   = r_min_key;
  assign min_idx   = r_min_idx;

endmodule
`default_nettype wire

// File: tb/tb_pheap_level_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pheap_level_reader
//  Description : Self-checking bench for pheap_level_reader (RAMLEVEL 3 and 2)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pheap_level_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  // ---------------- RAMLEVEL = 3 instance ----------------
  logic        start3, ready3;
  logic        busy3, done3, we_a3, we_b3;
  logic [1:0]  addr_a3, addr_b3;
  logic [31:0] q_a3, q_b3;
  logic        out_valid3, out_last3, min_valid3;
  logic [1:0]  out_idx3, min_idx3;
  logic [31:0] out_entry3;
  logic [15:0] min_key3;
  logic [31:0] mem3 [4];

  pheap_level_reader #(.RAMLEVEL(3), .ENTRY_W(32), .KEY_LSB(16), .KEY_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .we_a(we_a3), .we_b(we_b3), .addr_a(addr_a3), .addr_b(addr_b3),
    .q_a(q_a3), .q_b(q_b3), .out_valid(out_valid3), .out_ready(ready3),
    .out_idx(out_idx3), .out_entry(out_entry3), .out_last(out_last3),
    .min_valid(min_valid3), .min_key(min_key3), .min_idx(min_idx3));

  // ---------------- RAMLEVEL = 2 instance ----------------
  logic        start2, ready2;
  logic        busy2, done2, we_a2, we_b2;
  logic [0:0]  addr_a2, addr_b2;
  logic [31:0] q_a2, q_b2;
  logic        out_valid2, out_last2, min_valid2;
  logic [0:0]  out_idx2, min_idx2;
  logic [31:0] out_entry2;
  logic [15:0] min_key2;
  logic [31:0] mem2 [2];

  pheap_level_reader #(.RAMLEVEL(2), .ENTRY_W(32), .KEY_LSB(16), .KEY_W(16)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .we_a(we_a2), .we_b(we_b2), .addr_a(addr_a2), .addr_b(addr_b2),
    .q_a(q_a2), .q_b(q_b2), .out_valid(out_valid2), .out_ready(ready2),
    .out_idx(out_idx2), .out_entry(out_entry2), .out_last(out_last2),
    .min_valid(min_valid2), .min_key(min_key2), .min_idx(min_idx2));

  // Dual-port, 1-cycle, no-change RAM models (a write would corrupt contents)
  always @(posedge clk) begin
    if (we_a3) mem3[addr_a3] <= 32'hDEAD_BEEF; else q_a3 <= mem3[addr_a3];
    if (we_b3) mem3[addr_b3] <= 32'hDEAD_BEEF; else q_b3 <= mem3[addr_b3];
    if (we_a2) mem2[addr_a2] <= 32'hDEAD_BEEF; else q_a2 <= mem2[addr_a2];
    if (we_b2) mem2[addr_b2] <= 32'hDEAD_BEEF; else q_b2 <= mem2[addr_b2];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- out_ready driver ----------------
  int rmode = 0;
  int rcyc  = 0;
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       ready3 = 1'b1;
      1:       ready3 = ((rcyc % 3) == 0);
      default: ready3 = 1'($urandom_range(0, 1));
    endcase
    rcyc++;
  end

  // ---------------- stream monitor for RAMLEVEL=3 ----------------
  int          beat_idx_q[$];
  logic [31:0] beat_ent_q[$];
  bit          beat_last_q[$];
  int          sweep_d = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_entry;
  logic [1:0]  prev_idx;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("we3_zero", {we_a3, we_b3}, 0);
      chk("we2_zero", {we_a2, we_b2}, 0);
      if (prev_stall) begin
        chk("stall_valid", out_valid3, 1);
        chk("stall_entry", out_entry3, prev_entry);
        chk("stall_idx", out_idx3, prev_idx);
      end
      prev_stall = out_valid3 && !ready3;
      prev_entry = out_entry3;
      prev_idx   = out_idx3;
      if (busy3) begin
        chk("min_valid_while_busy", min_valid3, 0);
        chk("inflight_le4", ((2 * (int'(addr_a3) / 2 + 1) - sweep_d) <= 4), 1);
      end
      if (out_valid3 && ready3) begin
        beat_idx_q.push_back(int'(out_idx3));
        beat_ent_q.push_back(out_entry3);
        beat_last_q.push_back(out_last3);
        sweep_d++;
      end
    end else begin
      prev_stall = 0;
    end
  end

  // Run one sweep on the RAMLEVEL=3 instance; optionally pulse start mid-sweep
  task automatic sweep3(input int mode, input bit mid_start, output int cycles, output int first_valid);
    beat_idx_q.delete(); beat_ent_q.delete(); beat_last_q.delete();
    sweep_d = 0; rmode = mode; rcyc = 0;
    @(posedge clk); #2; start3 = 1'b1;
    @(posedge clk); #2; start3 = 1'b0;                // E0 was that edge
    chk("busy_after_start", busy3, 1);
    cycles = 0; first_valid = -1;
    while (cycles < 200) begin
      @(posedge clk); #2;
      cycles++;
      start3 = (mid_start && cycles == 3);
      if (first_valid < 0 && out_valid3) first_valid = cycles;
      if (done3) break;
    end
    start3 = 1'b0;
    chk("done_within_bound", (cycles < 200), 1);
    chk("busy_low_at_done", busy3, 0);
    chk("min_valid_at_done", min_valid3, 1);
    @(posedge clk); #2;
    chk("done_single_pulse", done3, 0);
  endtask

  // Compare the captured stream and min against the RAM contents
  task automatic check3(input logic [31:0] snap [4]);
    int          best_i;
    logic [15:0] best_k;
    chk("beat_count", beat_idx_q.size(), 4);
    for (int i = 0; i < 4 && i < beat_idx_q.size(); i++) begin
      chk("beat_idx", beat_idx_q[i], i);
      chk("beat_entry", beat_ent_q[i], mem3[i]);
      chk("beat_last", beat_last_q[i], (i == 3));
    end
    best_i = 0; best_k = mem3[0][31:16];
    for (int i = 1; i < 4; i++)
      if (mem3[i][31:16] < best_k) begin best_k = mem3[i][31:16]; best_i = i; end
    chk("min_key", min_key3, best_k);
    chk("min_idx", min_idx3, best_i);
    for (int i = 0; i < 4; i++) chk("ram_unchanged", mem3[i], snap[i]);
  endtask

  typedef struct {
    logic [63:0] keys;      // {k3,k2,k1,k0}
    int          mode;
    logic [15:0] mkey;
    int          midx;
    int          cyc;       // -1 : do not check
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] snap [4];
  int          cyc, fv, guard;

  initial begin
    tbl[0] = '{ {16'd3, 16'd9, 16'd3, 16'd5},             0, 16'd3,      1,  7 };
    tbl[1] = '{ {16'd3, 16'd9, 16'd3, 16'd5},             1, 16'd3,      1, -1 };
    tbl[2] = '{ {16'd7, 16'd7, 16'd7, 16'd7},             0, 16'd7,      0,  7 };
    tbl[3] = '{ {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 2, 16'h0000,   3, -1 };
    tbl[4] = '{ {16'd8, 16'd2, 16'd2, 16'd4},             1, 16'd2,      1, -1 };
    tbl[5] = '{ {16'd1, 16'd1, 16'd8, 16'd9},             0, 16'd1,      2,  7 };

    start3 = 0; start2 = 0; ready2 = 1; ready3 = 1;
    for (int i = 0; i < 4; i++) mem3[i] = '0;
    mem2[0] = '0; mem2[1] = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_addr", {addr_a3, addr_b3}, 0);
    chk("rst_out", {out_valid3, out_idx3, out_entry3, out_last3}, 0);
    chk("rst_min", {min_valid3, min_key3, min_idx3}, 0);
    chk("rst_u2", {busy2, done2, addr_a2, addr_b2, out_valid2, out_entry2, min_valid2, min_key2}, 0);
    @(negedge clk); rst_n = 1;

    // Table-driven sweeps
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++)
        mem3[i] = {tbl[v].keys[16*i +: 16], 16'hC000 | 16'(v << 4) | 16'(i)};
      snap = mem3;
      sweep3(tbl[v].mode, 0, cyc, fv);
      check3(snap);
      chk("tbl_min_key", min_key3, tbl[v].mkey);
      chk("tbl_min_idx", min_idx3, tbl[v].midx);
      chk("first_valid_latency", fv, 2);
      if (tbl[v].cyc > 0) chk("sweep_cycles", cyc, tbl[v].cyc);
    end

    // start while busy is ignored: same result, no second sweep
    sweep3(0, 1, cyc, fv);
    check3(snap);
    chk("busy_start_cycles", cyc, 7);
    repeat (4) begin
      @(posedge clk); #2;
      chk("no_second_sweep_busy", busy3, 0);
      chk("no_second_sweep_done", done3, 0);
    end

    // RAMLEVEL=2 sweep
    mem2[0] = {16'hFFFF, 16'h1111};
    mem2[1] = {16'h0000, 16'h2222};
    begin
      int nb;
      @(posedge clk); #2; start2 = 1;
      @(posedge clk); #2; start2 = 0;
      cyc = 0; nb = 0;
      while (cyc < 50) begin
        @(negedge clk);
        if (out_valid2 && ready2) begin
          chk("l2_idx", out_idx2, nb);
          chk("l2_entry", out_entry2, mem2[nb % 2]);
          chk("l2_last", out_last2, (nb == 1));
          nb++;
        end
        @(posedge clk); #2;
        cyc++;
        if (done2) break;
      end
      chk("l2_cycles", cyc, 5);
      chk("l2_beats", nb, 2);
      chk("l2_min_valid", min_valid2, 1);
      chk("l2_min_key", min_key2, 16'h0000);
      chk("l2_min_idx", min_idx2, 1);
    end

    // Reset mid-sweep after the second beat
    for (int i = 0; i < 4; i++) mem3[i] = {16'(10 - i), 16'(i)};
    beat_idx_q.delete(); beat_ent_q.delete(); beat_last_q.delete();
    sweep_d = 0; rmode = 0;
    @(posedge clk); #2; start3 = 1;
    @(posedge clk); #2; start3 = 0;
    guard = 0;
    while (beat_idx_q.size() < 2 && guard < 50) begin
      @(negedge clk); #1; guard++;
    end
    chk("reset_wait_bound", (guard < 50), 1);
    rst_n = 0;
    #1;
    chk("mid_rst_ctrl", {busy3, done3, addr_a3, addr_b3}, 0);
    chk("mid_rst_out", {out_valid3, out_idx3, out_entry3, out_last3}, 0);
    chk("mid_rst_min", {min_valid3, min_key3, min_idx3}, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("mid_rst_no_done", {done3, min_valid3}, 0);
    @(negedge clk); rst_n = 1;
    snap = mem3;
    sweep3(0, 0, cyc, fv);
    check3(snap);
    chk("post_rst_cycles", cyc, 7);

    // Randomized sweeps against the reference model
    for (int r = 0; r < 15; r++) begin
      for (int i = 0; i < 4; i++)
        mem3[i] = {16'($urandom_range(0, 3)), 16'($urandom)};
      snap = mem3;
      sweep3(2, 0, cyc, fv);
      check3(snap);
      chk("rand_first_valid", fv, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
